// File: rtl/fifo_wr_arbiter_if.sv
// Requester stream and FIFO write-side bundle for fifo_wr_arbiter.
// master is the arbiter's view; slave is the requester/FIFO environment's view.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DSIZE = 16
) ();

  localparam int unsigned IdW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_winc;
  logic [DSIZE-1:0]      fifo_wdata;
  logic                  fifo_wfull;
  logic                  fifo_awfull;
  logic [IdW-1:0]        grant_id;
  logic                  busy;

  modport master (
    input  req_valid, req_data, req_last, fifo_wfull, fifo_awfull,
    output req_ready, fifo_winc, fifo_wdata, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, req_last, fifo_wfull, fifo_awfull,
    input  req_ready, fifo_winc, fifo_wdata, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NREQ requesters.
// Define FIFO_WR_ARB_AWFULL_GATE_EN to block new grants while fifo_awfull is high.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DSIZE    = 16,
  parameter int unsigned MAXBURST = 8
) (
  input logic               wclk,
  input logic               wrst_n,
  fifo_wr_arbiter_if.master bus
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(MAXBURST + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  grant_q, grant_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;

  logic            arb_ok;
  logic            arb_found;
  logic [IdW-1:0]  arb_sel;
  logic            xfer;
  logic            burst_end;

`ifdef FIFO_WR_ARB_AWFULL_GATE_EN
  assign arb_ok = ~bus.fifo_awfull;
`else
  logic unused_awfull;
  assign unused_awfull = bus.fifo_awfull;
  assign arb_ok        = 1'b1;
`endif

  // First valid requester searching upward from rr_ptr+1, wrapping at NREQ.
  always_comb begin
    int unsigned idx;
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = (32'(rr_ptr_q) + off) % NREQ;
      if (!arb_found && bus.req_valid[IdW'(idx)]) begin
        arb_found = 1'b1;
        arb_sel   = IdW'(idx);
      end
    end
  end

  assign xfer      = (state_q == StBurst) & bus.req_valid[grant_q] & ~bus.fifo_wfull;
  assign burst_end = bus.req_last[grant_q] | ((32'(beat_cnt_q) + 32'd1) == MAXBURST);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= IdW'(NREQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (arb_found && arb_ok) begin
          state_d    = StBurst;
          grant_d    = arb_sel;
          beat_cnt_d = '0;
        end
      end
      StBurst: begin
        if (xfer) begin
          if (burst_end) begin
            state_d    = StIdle;
            rr_ptr_d   = grant_q;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Ready and write strobe are combinational on wfull so a full FIFO is never written.
  always_comb begin
    bus.req_ready  = '0;
    bus.fifo_winc  = 1'b0;
    bus.fifo_wdata = bus.req_data[grant_q*DSIZE +: DSIZE];
    bus.grant_id   = grant_q;
    bus.busy       = (state_q == StBurst);
    if (state_q == StBurst) begin
      bus.req_ready[grant_q] = ~bus.fifo_wfull;
      bus.fifo_winc          = bus.req_valid[grant_q] & ~bus.fifo_wfull;
    end
  end

endmodule
